// File: rtl/ehw_pkg.sv
// Shared definitions for the evolvable-hardware memory path: sizes and the
// population loader state encoding.
package ehw_pkg;

    localparam int EHW_MEM_AW = 9;
    localparam int EHW_MEM_DW = 64;
    localparam int EHW_RND_W  = 32;

    typedef enum logic [2:0] {
        LDR_IDLE = 3'd0,
        LDR_LO   = 3'd1,
        LDR_HI   = 3'd2,
        LDR_WR   = 3'd3,
        LDR_FIN  = 3'd4
    } ldr_state_t;

    function automatic logic ldr_accepts_rnd(input ldr_state_t st);
        return (st == LDR_LO) || (st == LDR_HI);
    endfunction

endpackage

// File: rtl/rnd_pop_loader.sv
// Packs pairs of random words into 64-bit chromosome words and writes them
// into a wrap-around BRAM range, then signals completion.
module rnd_pop_loader
    import ehw_pkg::*;
#(
    parameter int AW = EHW_MEM_AW,
    parameter int DW = EHW_MEM_DW,
    parameter int RW = EHW_RND_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   num_words,
    input  logic [RW-1:0] rnd_data,
    input  logic          rnd_valid,
    output logic          rnd_ready,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_di,
    output logic          busy,
    output logic          done,
    output logic          irq,
    input  logic          irq_ack
);

    ldr_state_t    state_r;
    ldr_state_t    state_next_s;
    logic [AW-1:0] addr_r;
    logic [AW:0]   rem_r;
    logic [DW-1:0] data_r;
    logic          irq_r;
    logic          irq_set_s;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= LDR_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode; abort overrides every other transition
    always_comb begin
        state_next_s = state_r;
        if (abort) begin
            state_next_s = LDR_IDLE;
        end else begin
            case (state_r)
                LDR_IDLE: begin
                    if (start) begin
                        state_next_s = (num_words == '0) ? LDR_FIN : LDR_LO;
                    end else begin
                        state_next_s = LDR_IDLE;
                    end
                end
                LDR_LO: begin
                    if (rnd_valid) state_next_s = LDR_HI;
                    else           state_next_s = LDR_LO;
                end
                LDR_HI: begin
                    if (rnd_valid) state_next_s = LDR_WR;
                    else           state_next_s = LDR_HI;
                end
                LDR_WR: begin
                    if (rem_r == (AW+1)'(1)) state_next_s = LDR_FIN;
                    else                     state_next_s = LDR_LO;
                end
                LDR_FIN: state_next_s = LDR_IDLE;
                default: state_next_s = LDR_IDLE;
            endcase
        end
    end

    // Address counter, remaining counter and packing register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_r <= '0;
            rem_r  <= '0;
            data_r <= '0;
        end else if (!abort) begin
            case (state_r)
                LDR_IDLE: begin
                    if (start) begin
                        addr_r <= base_addr;
                        rem_r  <= num_words;
                        data_r <= '0;
                    end
                end
                LDR_LO: begin
                    if (rnd_valid) data_r[DW-1:RW] <= rnd_data;
                end
                LDR_HI: begin
                    if (rnd_valid) data_r[RW-1:0] <= rnd_data;
                end
                LDR_WR: begin
                    addr_r <= addr_r + AW'(1);
                    rem_r  <= rem_r - (AW+1)'(1);
                end
                default: begin
                    addr_r <= addr_r;
                end
            endcase
        end
    end

    // Holding the set through FIN lets a same-cycle acknowledge lose to the set
    assign irq_set_s = (state_next_s == LDR_FIN) || (state_r == LDR_FIN);

    // Sticky completion interrupt
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_r <= 1'b0;
        end else if (irq_set_s) begin
            irq_r <= 1'b1;
        end else if (irq_ack) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= irq_r;
        end
    end

    assign rnd_ready = ldr_accepts_rnd(state_r);
    assign mem_en    = (state_r == LDR_WR);
    assign mem_we    = (state_r == LDR_WR);
    assign mem_addr  = addr_r;
    assign mem_di    = data_r;
    assign busy      = (state_r != LDR_IDLE);
    assign done      = (state_r == LDR_FIN);
    assign irq       = irq_r;

endmodule

// File: tb/tb_rnd_pop_loader.sv
// Self-checking bench for rnd_pop_loader: vector table of load jobs checked
// through a write scoreboard, plus reset/abort/start-while-busy sequences.
module tb_rnd_pop_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [8:0]  base_addr;
    logic [9:0]  num_words;
    logic [31:0] rnd_data;
    logic        rnd_valid;
    logic        rnd_ready;
    logic        mem_en;
    logic        mem_we;
    logic [8:0]  mem_addr;
    logic [63:0] mem_di;
    logic        busy;
    logic        done;
    logic        irq;
    logic        irq_ack;

    rnd_pop_loader dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .base_addr(base_addr), .num_words(num_words),
        .rnd_data(rnd_data), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_di(mem_di),
        .busy(busy), .done(done), .irq(irq), .irq_ack(irq_ack)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [8:0]  addr;
        logic [63:0] data;
    } wr_t;

    typedef struct {
        logic [8:0] base;
        logic [9:0] num;
        bit         toggle;
        bit         ack_fin;
    } vec_t;

    wr_t         exp_q[$];
    vec_t        vecs[5];
    logic [31:0] src[256];
    int          src_idx = 0;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          done_cnt;
    int          done_cyc;
    int          wr_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One clock: consume a word on handshake, then monitor outputs on negedge.
    task automatic tick();
        bit hs;
        wr_t e;
        hs = rnd_valid && rnd_ready;
        @(posedge clk);
        cyc++;
        if (hs) src_idx++;
        @(negedge clk);
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (mem_we || mem_en) begin
            chk("we_en_pair", {63'd0, mem_we}, {63'd0, mem_en});
            chk("no_ready_in_wr", {63'd0, rnd_ready}, 64'd0);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual_addr=%0h actual_data=%0h", mem_addr, mem_di);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", {55'd0, mem_addr}, {55'd0, e.addr});
                chk("wr_data", mem_di, e.data);
            end
            wr_cnt++;
        end
        rnd_data = src[src_idx];
    endtask

    task automatic run_load(input logic [8:0] base, input logic [9:0] num,
                            input bit toggle, input bit ack_fin);
        int t0;
        int n;
        bit phase;
        wr_t e;
        n = int'(num);
        for (int i = 0; i < n; i++) begin
            e.addr = base + 9'(i);
            e.data = {src[src_idx + 2*i], src[src_idx + 2*i + 1]};
            exp_q.push_back(e);
        end
        done_cnt = 0;
        done_cyc = -1;
        wr_cnt   = 0;
        base_addr = base;
        num_words = num;
        start = 1'b1;
        rnd_valid = 1'b0;
        tick();
        start = 1'b0;
        t0 = cyc;
        chk("busy_after_start", {63'd0, busy}, 64'd1);
        chk("ready_after_start", {63'd0, rnd_ready}, {63'd0, (n != 0)});
        phase = 1'b1;
        for (int k = 0; k < 300 && busy; k++) begin
            rnd_valid = toggle ? phase : 1'b1;
            phase = ~phase;
            irq_ack = ack_fin && (cyc == t0 + 3*n);
            tick();
        end
        irq_ack = 1'b0;
        rnd_valid = 1'b0;
        chk("load_finished", {63'd0, busy}, 64'd0);
        chk("done_pulses", 64'(done_cnt), 64'd1);
        if (!toggle) chk("done_cycle", 64'(done_cyc), 64'(t0 + 3*n));
        chk("write_count", 64'(wr_cnt), 64'(n));
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        chk("irq_after_load", {63'd0, irq}, 64'd1);
        exp_q.delete();
    endtask

    initial begin
        src[0] = 32'h11111111;
        src[1] = 32'h22222222;
        src[2] = 32'h33333333;
        src[3] = 32'h44444444;
        for (int i = 4; i < 256; i++) src[i] = $urandom;

        vecs[0] = '{base: 9'h010, num: 10'd2, toggle: 1'b0, ack_fin: 1'b0};
        vecs[1] = '{base: 9'h1FF, num: 10'd2, toggle: 1'b0, ack_fin: 1'b1};
        vecs[2] = '{base: 9'h0AB, num: 10'd3, toggle: 1'b1, ack_fin: 1'b0};
        vecs[3] = '{base: 9'h100, num: 10'd0, toggle: 1'b0, ack_fin: 1'b1};
        vecs[4] = '{base: 9'h1FE, num: 10'd4, toggle: 1'b0, ack_fin: 1'b0};

        reset = 1'b1; start = 1'b0; abort = 1'b0; irq_ack = 1'b0;
        rnd_valid = 1'b0; base_addr = 9'd0; num_words = 10'd0;
        rnd_data = src[0];
        done_cnt = 0; done_cyc = -1; wr_cnt = 0;
        repeat (3) @(negedge clk);
        chk("rst_outputs", {55'd0, rnd_ready, mem_en, mem_we, busy, done, irq, mem_addr},
            64'd0);
        chk("rst_mem_di", mem_di, 64'd0);
        reset = 1'b0;
        tick();

        // Vector table; the first entry uses the fixed words 0x11111111..0x44444444
        for (int v = 0; v < 5; v++) begin
            irq_ack = 1'b1;
            tick();
            irq_ack = 1'b0;
            chk("irq_ack_clears", {63'd0, irq}, 64'd0);
            run_load(vecs[v].base, vecs[v].num, vecs[v].toggle, vecs[v].ack_fin);
        end
        chk("first_pair_src", {src[0], src[1]}, 64'h1111111122222222);

        // Reset asserted while in HI
        base_addr = 9'h040; num_words = 10'd2; start = 1'b1;
        tick();
        start = 1'b0; rnd_valid = 1'b1;
        tick();
        chk("in_hi_ready", {62'd0, busy, rnd_ready}, 64'd3);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_outputs",
            {55'd0, rnd_ready, mem_en, mem_we, busy, done, irq, mem_addr}, 64'd0);
        chk("async_rst_mem_di", mem_di, 64'd0);
        rnd_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        chk("idle_after_rst", {63'd0, busy}, 64'd0);
        run_load(9'h020, 10'd1, 1'b0, 1'b0);

        // Start while busy ignored, then abort in HI of the second word
        done_cnt = 0; wr_cnt = 0;
        exp_q.push_back('{addr: 9'h030, data: {src[src_idx], src[src_idx + 1]}});
        base_addr = 9'h030; num_words = 10'd3; start = 1'b1;
        tick();
        base_addr = 9'h155; num_words = 10'd7; rnd_valid = 1'b1;
        tick();
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("second_word_hi", {62'd0, busy, rnd_ready}, 64'd3);
        abort = 1'b1; rnd_valid = 1'b0;
        tick();
        abort = 1'b0;
        chk("abort_to_idle", {63'd0, busy}, 64'd0);
        repeat (4) tick();
        chk("abort_no_done", 64'(done_cnt), 64'd0);
        chk("abort_writes", 64'(wr_cnt), 64'd1);
        chk("abort_irq_kept", {63'd0, irq}, 64'd1);
        exp_q.delete();

        // start and abort together in IDLE
        start = 1'b1; abort = 1'b1; num_words = 10'd1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", {63'd0, busy}, 64'd0);
        repeat (3) tick();
        chk("start_abort_no_write", 64'(wr_cnt), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
